// File: rtl/xc_aesmix.sv
// AES MixColumns / InvMixColumns on one 32-bit column with the AddRoundKey XOR folded in.
// ITERATIVE=1 shares one GF(2^8) constant-multiply network over four cycles; ITERATIVE=0 is combinational.
module xc_aesmix #(
  parameter int unsigned ITERATIVE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        enc,
  output logic        ready,
  output logic [31:0] result
);

  localparam int unsigned COL_W  = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 2;

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // One output byte: row {2,3,1,1} (enc) or {E,B,D,9} (dec) applied to {x3,x2,x1,x0}.
  function automatic logic [BYTE_W-1:0] mix_byte(input logic [COL_W-1:0] col,
                                                 input logic             fwd);
    logic [BYTE_W-1:0] x  [4];
    logic [BYTE_W-1:0] x2 [4];
    logic [BYTE_W-1:0] x4 [4];
    logic [BYTE_W-1:0] x8 [4];
    logic [BYTE_W-1:0] m_enc;
    logic [BYTE_W-1:0] m_dec;
    for (int j = 0; j < 4; j++) begin
      x[j]  = col[BYTE_W*j +: BYTE_W];
      x2[j] = xtime(x[j]);
      x4[j] = xtime(x2[j]);
      x8[j] = xtime(x4[j]);
    end
    m_enc = x2[0] ^ (x2[1] ^ x[1]) ^ x[2] ^ x[3];
    m_dec = (x8[0] ^ x4[0] ^ x2[0]) ^ (x8[1] ^ x2[1] ^ x[1])
          ^ (x8[2] ^ x4[2] ^ x[2]) ^ (x8[3] ^ x[3]);
    return fwd ? m_enc : m_dec;
  endfunction

  // Rotate right by sel bytes so byte c[sel] lands in the low lane.
  function automatic logic [COL_W-1:0] rotr(input logic [COL_W-1:0] col,
                                            input logic [CNT_W-1:0] sel);
    logic [COL_W-1:0] r;
    r = col;
    case (sel)
      2'd0: r = col;
      2'd1: r = {col[7:0],  col[31:8]};
      2'd2: r = {col[15:0], col[31:16]};
      2'd3: r = {col[23:0], col[31:24]};
      default: r = col;
    endcase
    return r;
  endfunction

  generate
    if (ITERATIVE != 0) begin : g_iter
      typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

      state_t            state_q, state_d;
      logic [CNT_W-1:0]  cnt_q;
      logic [COL_W-1:0]  opnd_q;
      logic [COL_W-1:0]  key_q;
      logic [COL_W-1:0]  acc_q;
      logic              enc_q;
      logic              ready_q;
      logic [COL_W-1:0]  result_q;
      logic              load;
      logic              step;
      logic              finish;
      logic [BYTE_W-1:0] byte_val;
      logic [COL_W-1:0]  final_col;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
      end

      // Dropping valid while BUSY aborts the operation without a ready pulse.
      always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
          IDLE: begin
            if (valid) begin
              load    = 1'b1;
              state_d = BUSY;
            end
          end
          BUSY: begin
            if (!valid) begin
              state_d = IDLE;
            end else begin
              step = 1'b1;
              if (cnt_q == CNT_W'(3)) begin
                finish  = 1'b1;
                state_d = DONE;
              end
            end
          end
          DONE:    state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end

      assign byte_val  = mix_byte(rotr(opnd_q, cnt_q), enc_q);
      assign final_col = {byte_val, acc_q[23:0]};

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          cnt_q    <= '0;
          opnd_q   <= '0;
          key_q    <= '0;
          acc_q    <= '0;
          enc_q    <= 1'b0;
          ready_q  <= 1'b0;
          result_q <= '0;
        end else begin
          ready_q <= finish;
          if (load) begin
            opnd_q <= enc ? rs1 : (rs1 ^ rs2);
            key_q  <= rs2;
            enc_q  <= enc;
            cnt_q  <= '0;
          end
          if (step) begin
            acc_q[BYTE_W*cnt_q +: BYTE_W] <= byte_val;
            cnt_q <= cnt_q + CNT_W'(1);
          end
          // Result register is written only on completion, so it holds across IDLE and aborts.
          if (finish) begin
            result_q <= enc_q ? (final_col ^ key_q) : final_col;
          end
        end
      end

      assign ready  = ready_q;
      assign result = result_q;
    end else begin : g_comb
      logic [COL_W-1:0] col;
      logic [COL_W-1:0] mixed;

      always_comb begin
        col   = enc ? rs1 : (rs1 ^ rs2);
        mixed = '0;
        for (int i = 0; i < 4; i++) begin
          mixed[BYTE_W*i +: BYTE_W] = mix_byte(rotr(col, CNT_W'(i)), enc);
        end
      end

      assign ready  = valid;
      assign result = valid ? (enc ? (mixed ^ rs2) : mixed) : '0;
    end
  endgenerate

endmodule
